// File: rtl/muldiv_pkg.sv
// Shared definitions for the iterative multiply/divide unit:
// operation encodings and the control FSM state type.
package muldiv_pkg;

    localparam logic [1:0] OP_MULT  = 2'd0;
    localparam logic [1:0] OP_MULTU = 2'd1;
    localparam logic [1:0] OP_DIV   = 2'd2;
    localparam logic [1:0] OP_DIVU  = 2'd3;

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        FIXUP,
        DONE
    } state_e;

endpackage

// File: rtl/muldiv_negate.sv
// Conditional two's-complement negator.
// Ports: in_i (value), neg_i (negate when 1), out_o (result).
module muldiv_negate #(
    parameter int W = 32
) (
    input  logic [W-1:0] in_i,
    input  logic         neg_i,
    output logic [W-1:0] out_o
);

    assign out_o = neg_i ? (~in_i + W'(1)) : in_i;

endmodule

// File: rtl/muldiv_seq.sv
// Iterative multiply/divide unit, one result bit per cycle.
// Ports: clk, rst (sync, high), flush, start, op, a, b in;
//        busy, done, result {hi,lo}, div_zero (MULDIV_DIV0_EN) out.
module muldiv_seq
    import muldiv_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               flush,
    input  logic               start,
    input  logic [1:0]         op,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic               busy,
    output logic               done,
    output logic [2*WIDTH-1:0] result
`ifdef MULDIV_DIV0_EN
    ,
    output logic               div_zero
`endif
);

    localparam int CNT_W = $clog2(WIDTH) + 1;

    state_e             state_q;
    logic [1:0]         op_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [2*WIDTH:0]   work_q;
    logic [2*WIDTH:0]   work_d;
    logic [WIDTH-1:0]   mcand_q;
    logic               neg_lo_q;
    logic               neg_hi_q;
    logic               busy_q;
    logic               done_q;
    logic [2*WIDTH-1:0] result_q;
`ifdef MULDIV_DIV0_EN
    logic               dz_pend_q;
    logic               div_zero_q;
`endif

    logic               sgn_in;
    logic               a_neg;
    logic               b_neg;
    logic               b_zero;
    logic [WIDTH-1:0]   a_mag;
    logic [WIDTH-1:0]   b_mag;
    logic [WIDTH:0]     acc_sum;
    logic [WIDTH:0]     rem_sh;
    logic [WIDTH+1:0]   diff;
    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0]   quo_fix;
    logic [WIDTH-1:0]   rem_fix;
    logic [2*WIDTH-1:0] fix_res;

    assign sgn_in = (op == OP_MULT) || (op == OP_DIV);
    assign a_neg  = sgn_in & a[WIDTH-1];
    assign b_neg  = sgn_in & b[WIDTH-1];
    assign b_zero = (b == '0);

    muldiv_negate #(.W(WIDTH)) u_neg_a (
        .in_i  (a),
        .neg_i (a_neg),
        .out_o (a_mag)
    );

    muldiv_negate #(.W(WIDTH)) u_neg_b (
        .in_i  (b),
        .neg_i (b_neg),
        .out_o (b_mag)
    );

    // work_q, mult: {carry, acc_hi, multiplier}, shifted right.
    // work_q, div:  {partial rem, quotient/dividend}, shifted left.
    always_comb begin
        acc_sum = work_q[2*WIDTH:WIDTH]
                + (work_q[0] ? {1'b0, mcand_q} : '0);
        rem_sh  = work_q[2*WIDTH-1:WIDTH-1];
        diff    = {1'b0, rem_sh} - {2'b00, mcand_q};
        work_d  = {1'b0, acc_sum, work_q[WIDTH-1:1]};
        if (op_q[1]) begin
            if (diff[WIDTH+1]) begin
                work_d = {work_q[2*WIDTH-1:0], 1'b0};
            end else begin
                work_d = {diff[WIDTH:0], work_q[WIDTH-2:0], 1'b1};
            end
        end
    end

    muldiv_negate #(.W(2*WIDTH)) u_neg_prod (
        .in_i  (work_q[2*WIDTH-1:0]),
        .neg_i (neg_lo_q),
        .out_o (prod_fix)
    );

    muldiv_negate #(.W(WIDTH)) u_neg_quo (
        .in_i  (work_q[WIDTH-1:0]),
        .neg_i (neg_lo_q),
        .out_o (quo_fix)
    );

    muldiv_negate #(.W(WIDTH)) u_neg_rem (
        .in_i  (work_q[2*WIDTH-1:WIDTH]),
        .neg_i (neg_hi_q),
        .out_o (rem_fix)
    );

    assign fix_res = op_q[1] ? {rem_fix, quo_fix} : prod_fix;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            op_q       <= '0;
            cnt_q      <= '0;
            work_q     <= '0;
            mcand_q    <= '0;
            neg_lo_q   <= 1'b0;
            neg_hi_q   <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            result_q   <= '0;
`ifdef MULDIV_DIV0_EN
            dz_pend_q  <= 1'b0;
            div_zero_q <= 1'b0;
`endif
        end else if (flush) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            unique case (state_q)
                IDLE, DONE: begin
                    done_q <= 1'b0;
                    if (start) begin
                        op_q     <= op;
                        mcand_q  <= b_mag;
                        neg_hi_q <= a_neg;
                        // divide-by-zero keeps an all-ones quotient
                        neg_lo_q <= (a_neg ^ b_neg) & ~(op[1] & b_zero);
                        work_q   <= {{(WIDTH+1){1'b0}}, a_mag};
                        cnt_q    <= CNT_W'(WIDTH);
                        busy_q   <= 1'b1;
                        state_q  <= CALC;
`ifdef MULDIV_DIV0_EN
                        dz_pend_q <= op[1] & b_zero;
                        if (op[1] & b_zero) begin
                            work_q  <= {1'b0, a_mag, {WIDTH{1'b1}}};
                            state_q <= FIXUP;
                        end
`endif
                    end else begin
                        busy_q  <= 1'b0;
                        state_q <= IDLE;
                    end
                end
                CALC: begin
                    work_q <= work_d;
                    cnt_q  <= cnt_q - CNT_W'(1);
                    if (cnt_q == CNT_W'(1)) begin
                        state_q <= FIXUP;
                    end
                end
                FIXUP: begin
                    result_q <= fix_res;
                    busy_q   <= 1'b0;
                    done_q   <= 1'b1;
                    state_q  <= DONE;
`ifdef MULDIV_DIV0_EN
                    div_zero_q <= dz_pend_q;
`endif
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign busy   = busy_q;
    assign done   = done_q;
    assign result = result_q;
`ifdef MULDIV_DIV0_EN
    assign div_zero = div_zero_q;
`endif

endmodule

// File: tb/tb_muldiv_seq.sv
// Scoreboard bench for muldiv_seq: directed plan vectors plus
// randomized ops against an arithmetic reference model.
module tb_muldiv_seq;
    import muldiv_pkg::*;

    localparam int W = 32;
`ifdef MULDIV_DIV0_EN
    localparam bit DZ_EN = 1'b1;
`else
    localparam bit DZ_EN = 1'b0;
`endif

    logic           clk = 1'b0;
    logic           rst;
    logic           flush;
    logic           start;
    logic [1:0]     op;
    logic [W-1:0]   a;
    logic [W-1:0]   b;
    logic           busy;
    logic           done;
    logic [2*W-1:0] result;
`ifdef MULDIV_DIV0_EN
    logic           div_zero;
`endif

    muldiv_seq #(.WIDTH(W)) dut (
        .clk      (clk),
        .rst      (rst),
        .flush    (flush),
        .start    (start),
        .op       (op),
        .a        (a),
        .b        (b),
        .busy     (busy),
        .done     (done),
        .result   (result)
`ifdef MULDIV_DIV0_EN
        ,
        .div_zero (div_zero)
`endif
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [63:0] res;
        logic        dz;
        int          t0;
        int          lat;
        string       nm;
    } exp_t;

    exp_t        exp_q[$];
    logic [63:0] last_res = '0;

    function automatic void chk(string nm, logic [63:0] act,
                                logic [63:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got 0x%h, expected 0x%h", nm, act, expv);
        end
    endfunction

    function automatic logic [63:0] model(logic [1:0] o,
                                          logic [31:0] x,
                                          logic [31:0] y);
        longint          sx;
        longint          sy;
        longint unsigned ux;
        longint unsigned uy;
        longint          q;
        longint          r;
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        ux = {32'd0, x};
        uy = {32'd0, y};
        if (o[1] && y == 32'd0) return {x, 32'hFFFF_FFFF};
        case (o)
            OP_MULT:  return 64'(sx * sy);
            OP_MULTU: return ux * uy;
            OP_DIV: begin
                q = sx / sy;
                r = sx % sy;
                return {r[31:0], q[31:0]};
            end
            default: begin
                q = longint'(ux / uy);
                r = longint'(ux % uy);
                return {r[31:0], q[31:0]};
            end
        endcase
    endfunction

    always @(negedge clk) begin
        exp_t e;
        if (!rst && done) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done: got done=1 at cycle %0d, expected 0",
                         cyc);
            end else begin
                e = exp_q.pop_front();
                chk({e.nm, "_result"}, result, e.res);
                chk({e.nm, "_latency"}, 64'(cyc - e.t0), 64'(e.lat));
`ifdef MULDIV_DIV0_EN
                chk({e.nm, "_div_zero"}, 64'(div_zero), 64'(e.dz));
`endif
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [1:0] o, input logic [31:0] x,
                         input logic [31:0] y, input logic [63:0] er,
                         input logic edz, input int lat,
                         input bit push, input string nm);
        op    = o;
        a     = x;
        b     = y;
        start = 1'b1;
        if (push) begin
            exp_q.push_back('{er, edz, cyc, lat, nm});
            last_res = er;
        end
        @(posedge clk);
        #1;
        start = 1'b0;
        op    = 2'($urandom);
        a     = $urandom;
        b     = $urandom;
    endtask

    task automatic wait_done(input string nm, output int bc);
        bit seen;
        seen = 1'b0;
        bc   = 0;
        for (int i = 0; i < 100 && !seen; i++) begin
            @(negedge clk);
            if (done) seen = 1'b1;
            else if (busy) bc++;
        end
        checks++;
        if (!seen) begin
            errors++;
            $display("FAIL %s_timeout: got no done in 100 cycles, expected done",
                     nm);
        end
    endtask

    function automatic int lat_of(logic [1:0] o, logic [31:0] y);
        return (DZ_EN && o[1] && y == 32'd0) ? 2 : W + 2;
    endfunction

    initial begin
        int          bc;
        logic [1:0]  o;
        logic [31:0] x;
        logic [31:0] y;
        int          sel;

        rst   = 1'b1;
        flush = 1'b0;
        start = 1'b0;
        op    = '0;
        a     = '0;
        b     = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_result", result, 64'd0);
        rst = 1'b0;
        step();

        issue(OP_MULT, 32'hFFFF_FFFE, 32'h0000_0003,
              64'hFFFF_FFFF_FFFF_FFFA, 1'b0, 34, 1'b1, "mult_neg");
        wait_done("mult_neg", bc);
        chk("mult_busy_cycles", 64'(bc), 64'd33);
        step();

        issue(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
              64'hFFFF_FFFE_0000_0001, 1'b0, 34, 1'b1, "multu_max");
        wait_done("multu_max", bc);
        step();

        issue(OP_DIV, 32'hFFFF_FFF9, 32'h0000_0002,
              64'hFFFF_FFFF_FFFF_FFFD, 1'b0, 34, 1'b1, "div_neg7");
        wait_done("div_neg7", bc);
        step();

        issue(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF,
              64'h0000_0000_8000_0000, 1'b0, 34, 1'b1, "div_ovf");
        wait_done("div_ovf", bc);
        step();

        issue(OP_DIVU, 32'd5, 32'd0, 64'h0000_0005_FFFF_FFFF,
              DZ_EN, DZ_EN ? 2 : 34, 1'b1, "divu_zero");
        wait_done("divu_zero", bc);
        step();

        // flushed MULT: no expectation queued, so any done is caught
        issue(OP_MULT, 32'h0000_1234, 32'h0000_5678, '0, 1'b0, 0,
              1'b0, "mult_flushed");
        repeat (8) step();
        flush = 1'b1;
        step();
        flush = 1'b0;
        chk("flush_busy", 64'(busy), 64'd0);
        chk("flush_done", 64'(done), 64'd0);
        chk("flush_result", result, last_res);
        step();
        issue(OP_MULTU, 32'd7, 32'd9, 64'd63, 1'b0, 34, 1'b1,
              "after_flush");
        wait_done("after_flush", bc);
        step();

        issue(OP_MULT, 32'd100, 32'hFFFF_FFFD, 64'hFFFF_FFFF_FFFF_FED4,
              1'b0, 34, 1'b1, "b2b_first");
        wait_done("b2b_first", bc);
        issue(OP_DIVU, 32'd1000, 32'd7, model(OP_DIVU, 32'd1000, 32'd7),
              1'b0, 34, 1'b1, "b2b_second");
        chk("b2b_busy", 64'(busy), 64'd1);
        wait_done("b2b_second", bc);
        step();

        for (int n = 0; n < 80; n++) begin
            o   = 2'($urandom_range(0, 3));
            x   = $urandom;
            sel = $urandom_range(0, 9);
            if ($urandom_range(0, 7) == 0) x = 32'h8000_0000;
            case (sel)
                0: y = 32'd0;
                1: y = 32'hFFFF_FFFF;
                2: y = 32'($urandom_range(1, 17));
                default: y = $urandom;
            endcase
            issue(o, x, y, model(o, x, y),
                  DZ_EN && o[1] && (y == 32'd0), lat_of(o, y),
                  1'b1, "rand");
            wait_done("rand", bc);
            if (n % 3 != 0) step();
        end
        step();

        issue(OP_DIV, 32'h0000_0F00, 32'h0000_0003, '0, 1'b0, 0,
              1'b0, "div_reset");
        repeat (5) step();
        rst = 1'b1;
        step();
        chk("midrst_busy", 64'(busy), 64'd0);
        chk("midrst_done", 64'(done), 64'd0);
        chk("midrst_result", result, 64'd0);
`ifdef MULDIV_DIV0_EN
        chk("midrst_div_zero", 64'(div_zero), 64'd0);
`endif
        rst = 1'b0;
        repeat (40) step();
        chk("drain_queue", 64'(exp_q.size()), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule

// File: doc/muldiv_seq.md
# muldiv_seq

Parametrised iterative multiply/divide unit for the EX stage; the next generation of the ALU's mult/div path. Replaces the edge-triggered busy/ready scheme with a single-clock FSM and an explicit start/busy/done handshake. Operates on WIDTH-bit operands and returns a 2*WIDTH-bit {hi, lo} result for the HI/LO register write-back.

## Interface
- WIDTH, 32, operand width; even, >= 4
- CNT_W, $clog2(WIDTH)+1, iteration counter width (derived, not overridden)
- clk  in  1  clock; all logic on rising edge
- rst  in  1  synchronous, active-high reset
- flush  in  1  abort the in-flight operation (EX flush)
- start  in  1  request; sampled only when not busy
- op  in  2  0 MULT, 1 MULTU, 2 DIV, 3 DIVU
- a  in  WIDTH  multiplicand / dividend
- b  in  WIDTH  multiplier / divisor
- busy  out  1  operation in flight; drives the EX stall
- done  out  1  one-cycle pulse: result valid
- result  out  2*WIDTH  {hi, lo}; product {upper, lower}; division {remainder, quotient}
- div_zero  out  1  present only with MULDIV_DIV0_EN

## Operation
- FSM states: IDLE, CALC, FIXUP, DONE.
- IDLE/DONE: start & ~flush captures op, a, b. Signed ops store magnitudes plus the result signs: product sign a^b; quotient sign a^b; remainder sign a. Counter loads WIDTH. Next state CALC.
- CALC, MULT*: radix-2 shift-add on 2*WIDTH accumulator, one multiplier bit per cycle.
- CALC, DIV*: restoring division, one quotient bit per cycle; WIDTH+1-bit partial remainder.
- Counter decrements each CALC cycle; at 1 -> FIXUP.
- FIXUP: two's-complement negate product/quotient/remainder per stored signs; register result. Next state DONE.
- DONE: done=1 for exactly this cycle; returns to IDLE unless a new start is accepted.
- result holds its value until the next FIXUP; it is not cleared by flush.
- Division by zero: quotient = all ones, remainder = a (unsigned and signed alike; no sign fixup).
- Signed overflow, a = -2^(WIDTH-1) and b = -1: quotient = -2^(WIDTH-1), remainder = 0. Falls out of magnitude arithmetic; no special case is required.
- start while busy: ignored; the caller holds start until done.
- flush in any state: next state IDLE. No done pulse, result unchanged. A flush coinciding with start wins, and the start is dropped.
- rst: state IDLE, busy 0, done 0, result 0, div_zero 0; overrides flush and start.

## Timing
- Start sampled at edge 0; CALC occupies cycles 1..WIDTH; FIXUP is cycle WIDTH+1; done is high in cycle WIDTH+2.
- Latency is WIDTH+2 cycles, identical for all ops. WIDTH=32 gives 34.
- busy is high in cycles 1..WIDTH+1 and low in the done cycle.
- Back-to-back: a start accepted in the DONE cycle gives busy again in the next cycle, with no bubble.
- Operands may change after the start cycle.

## Configuration
- MULDIV_DIV0_EN defined:
  - adds the div_zero port, set with done and held with result.
  - DIV/DIVU with b == 0 bypasses CALC: IDLE -> FIXUP -> DONE, so done comes 2 cycles after start.
- MULDIV_DIV0_EN undefined:
  - no div_zero port.
  - division by zero runs the full WIDTH+2 cycles and produces the same result values.

## Structure
- Shared package (muldiv_pkg): op encoding constants (OP_MULT, OP_MULTU, OP_DIV, OP_DIVU) and the FSM state enum.
- One sub-module, muldiv_negate: a parametrised conditional two's-complement negator, instantiated for magnitude capture and for FIXUP.
- Everything else stays in one module; the datapath is shared between mult and div through a single 2*WIDTH+1 working register.

## Test plan
- MULT a=0xFFFFFFFE (-2), b=0x00000003 -> result 0xFFFFFFFF_FFFFFFFA; done exactly 34 cycles after start; busy high for 33 cycles.
- MULTU a=0xFFFFFFFF, b=0xFFFFFFFF -> result 0xFFFFFFFE_00000001.
- DIV a=-7 (0xFFFFFFF9), b=2 -> hi=0xFFFFFFFF (-1), lo=0xFFFFFFFD (-3).
- DIV a=0x80000000, b=0xFFFFFFFF -> lo=0x80000000, hi=0.
- DIVU a=5, b=0 -> lo=0xFFFFFFFF, hi=5.
  - With MULDIV_DIV0_EN: done at cycle 2 and div_zero=1.
  - Without it: done at cycle 34.
- Flush at cycle 10 of a MULT -> busy low at cycle 11, no done, result keeps its previous value. A new start at cycle 12 completes normally.
- Back-to-back: start asserted in the DONE cycle -> second done 34 cycles later.
- rst asserted mid-DIV -> all outputs return to 0 at the next edge.
